// File: rtl/uut_exec_pkg.sv
// Shared types and default parameters for the UUT execution controller.
package uut_exec_pkg;

    localparam int unsigned DEF_MAX_LOG2 = 7;
    localparam int unsigned DEF_SEL_W    = 3;
    localparam int unsigned DEF_CNT_W    = 32;
    localparam int unsigned DEF_RST_CYC  = 4;
    localparam int unsigned DEF_TIMEOUT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESET_UUT = 2'd1,
        ST_RUN       = 2'd2,
        ST_DONE      = 2'd3
    } exec_state_e;

    // States in which the UUT receives clock-enable pulses.
    function automatic logic is_active(input exec_state_e s);
        return (s == ST_RESET_UUT) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/uut_exec_ctrl_if.sv
// Control/status bundle between a run requester and the UUT execution controller.
interface uut_exec_ctrl_if
    import uut_exec_pkg::*;
#(
    parameter int unsigned SEL_W = DEF_SEL_W,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             start;
    logic [SEL_W-1:0] div_sel;
    logic             end_uut;
    logic             clk_en_uut;
    logic             rst_uut;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, div_sel, end_uut,
        input  clk_en_uut, rst_uut, busy, done, timeout, cycles
    );

    modport slave (
        input  start, div_sel, end_uut,
        output clk_en_uut, rst_uut, busy, done, timeout, cycles
    );
endinterface

// File: rtl/uut_tick_gen.sv
// Free-running divider; tick is high when the low 'exponent' counter bits are all ones.
module uut_tick_gen
    import uut_exec_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = DEF_MAX_LOG2,
    parameter int unsigned SEL_W    = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [SEL_W-1:0] exponent,
    output logic             tick
);

    logic [MAX_LOG2-1:0] cnt_q;
    logic [MAX_LOG2-1:0] mask_c;

    // Thermometer mask of the counter bits that take part in the tick decode.
    always_comb begin
        mask_c = '0;
        for (int unsigned i = 0; i < MAX_LOG2; i++) begin
            mask_c[i] = (i < 32'(exponent));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + MAX_LOG2'(1);
        end
    end

    assign tick = &(cnt_q | ~mask_c);

endmodule

// File: rtl/uut_exec_ctrl.sv
// Runs a UUT: holds it in reset for RST_CYC ticks, counts run ticks until end_uut or the tick limit.
module uut_exec_ctrl
    import uut_exec_pkg::*;
#(
    parameter int unsigned MAX_LOG2 = DEF_MAX_LOG2,
    parameter int unsigned SEL_W    = DEF_SEL_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned RST_CYC  = DEF_RST_CYC,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    uut_exec_ctrl_if.slave  bus
);

    localparam int unsigned      RC_W      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST   = RC_W'(RST_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_MAX   = SEL_W'(MAX_LOG2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic             LIMIT_EN  = (TIMEOUT != 0);

    logic [1:0]       sync_q;
    logic             rst_s;
    exec_state_e      state_q, state_d;
    logic [SEL_W-1:0] exp_q, exp_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic [CNT_W-1:0] cycles_q, cycles_d, cycles_inc_c;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             rst_uut_q, rst_uut_d;
    logic             clk_en_q, clk_en_d;
    logic             start_ok_c;
    logic             tick_c;

    // Asynchronous assertion, release retimed through two flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_s = sync_q[1];

    assign start_ok_c = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    uut_tick_gen #(
        .MAX_LOG2 (MAX_LOG2),
        .SEL_W    (SEL_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst_s),
        .clear    (start_ok_c),
        .exponent (exp_q),
        .tick     (tick_c)
    );

    assign cycles_inc_c = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

    // Next-state and next-output decode; the FSM acts on the registered clock-enable,
    // i.e. on the cycle in which the UUT actually advances.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        rc_d      = rc_q;
        cycles_d  = cycles_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        rst_uut_d = rst_uut_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_RESET_UUT;
                    exp_d     = (bus.div_sel > SEL_MAX) ? SEL_MAX : bus.div_sel;
                    rc_d      = '0;
                    cycles_d  = '0;
                    busy_d    = 1'b1;
                    timeout_d = 1'b0;
                    rst_uut_d = 1'b1;
                end
            end
            ST_RESET_UUT: begin
                if (clk_en_q) begin
                    if (rc_q == RC_LAST) begin
                        state_d   = ST_RUN;
                        rst_uut_d = 1'b0;
                    end else begin
                        rc_d = rc_q + RC_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (clk_en_q) begin
                    cycles_d = cycles_inc_c;
                    if (bus.end_uut) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (LIMIT_EN && (cycles_inc_c == CNT_LIMIT)) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        clk_en_d = tick_c && is_active(state_q) && is_active(state_d);
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            rc_q      <= '0;
            cycles_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rst_uut_q <= 1'b1;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            rc_q      <= rc_d;
            cycles_q  <= cycles_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            rst_uut_q <= rst_uut_d;
            clk_en_q  <= clk_en_d;
        end
    end

    assign bus.clk_en_uut = clk_en_q;
    assign bus.rst_uut    = rst_uut_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycles     = cycles_q;

endmodule

// File: tb/tb_uut_exec_ctrl.sv
// Bench for uut_exec_ctrl: two configurations driven in lockstep and checked every cycle
// against a timeline model derived from tick period, reset length and run length.
module tb_uut_exec_ctrl;

    localparam int    A_MAX  = 7;
    localparam int    A_RST  = 4;
    localparam int    A_TO   = 10;
    localparam longint A_CMAX = 64'hFFFF_FFFF;
    localparam int    B_MAX  = 3;
    localparam int    B_RST  = 2;
    localparam longint B_CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uut_exec_ctrl_if #(.SEL_W(3), .CNT_W(32)) ia ();
    uut_exec_ctrl_if #(.SEL_W(3), .CNT_W(4))  ib ();

    uut_exec_ctrl #(
        .MAX_LOG2(A_MAX), .SEL_W(3), .CNT_W(32), .RST_CYC(A_RST), .TIMEOUT(A_TO)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    uut_exec_ctrl #(
        .MAX_LOG2(B_MAX), .SEL_W(3), .CNT_W(4), .RST_CYC(B_RST), .TIMEOUT(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    // Expected outputs j cycles after the accepted start: ticks every p cycles, r reset
    // ticks, e counted run ticks, to = run ends on the tick limit. flags = {en,rst,busy,done,to}.
    function automatic void model(input int j, input int p, input int r, input int e,
                                  input bit to, input longint cmax,
                                  output logic [4:0] flags, output longint cyc);
        int t;
        longint k;
        t = r + e;
        flags[4] = (j > 0) && (j % p == 0) && (j / p <= t);
        flags[3] = (j <= r * p);
        flags[2] = (j <= t * p);
        flags[1] = (j == t * p + 1);
        flags[0] = to && (j > t * p);
        k = (j == 0) ? 0 : longint'((j - 1) / p - r);
        if (k < 0) k = 0;
        if (k > e) k = e;
        if (k > cmax) k = cmax;
        cyc = k;
    endfunction

    // end_uut: high on run ticks >= n, random on every other cycle.
    function automatic logic end_stim(input int j, input int p, input int r, input int e, input int n);
        int m;
        m = j / p - r;
        if ((j > 0) && (j % p == 0) && (m >= 1) && (m <= e)) return (m >= n);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_case(input string name, input int sel, input int n, input bit noise,
                            input int hold, input int abort_j);
        int pa, pb, ea, eb, ta, tb2, jmax, jsafe;
        bit toa;
        logic [4:0] exp_a, exp_b, act_a, act_b;
        longint ca, cb;
        logic st;
        pa  = 1 << ((sel > A_MAX) ? A_MAX : sel);
        pb  = 1 << ((sel > B_MAX) ? B_MAX : sel);
        toa = (n > A_TO);
        ea  = toa ? A_TO : n;
        eb  = n;
        ta  = (A_RST + ea) * pa;
        tb2 = (B_RST + eb) * pb;
        jmax  = ((ta > tb2) ? ta : tb2) + 1 + hold;
        jsafe = (ta < tb2) ? ta : tb2;
        ia.start = 1'b1;  ib.start = 1'b1;
        ia.div_sel = 3'(sel);  ib.div_sel = 3'(sel);
        @(posedge clk);
        for (int j = 0; j <= jmax; j++) begin
            @(negedge clk);
            model(j, pa, A_RST, ea, toa, A_CMAX, exp_a, ca);
            model(j, pb, B_RST, eb, 1'b0, B_CMAX, exp_b, cb);
            act_a = {ia.clk_en_uut, ia.rst_uut, ia.busy, ia.done, ia.timeout};
            act_b = {ib.clk_en_uut, ib.rst_uut, ib.busy, ib.done, ib.timeout};
            checks++;
            if (act_a !== exp_a) begin
                errors++;
                $display("FAIL %s a_flags j=%0d got %b exp %b (en,rst,busy,done,to)", name, j, act_a, exp_a);
            end
            checks++;
            if (ia.cycles !== 32'(ca)) begin
                errors++;
                $display("FAIL %s a_cycles j=%0d got %0d exp %0d", name, j, ia.cycles, ca);
            end
            checks++;
            if (act_b !== exp_b) begin
                errors++;
                $display("FAIL %s b_flags j=%0d got %b exp %b (en,rst,busy,done,to)", name, j, act_b, exp_b);
            end
            checks++;
            if (ib.cycles !== 4'(cb)) begin
                errors++;
                $display("FAIL %s b_cycles j=%0d got %0d exp %0d", name, j, ib.cycles, cb);
            end
            if (j == abort_j) return;
            st = (noise && (j < jsafe)) ? 1'($urandom_range(0, 1)) : 1'b0;
            ia.start = st;  ib.start = st;
            ia.div_sel = 3'($urandom_range(0, 7));
            ib.div_sel = ia.div_sel;
            ia.end_uut = end_stim(j, pa, A_RST, ea, n);
            ib.end_uut = end_stim(j, pb, B_RST, eb, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ia.start = 1'b0;  ib.start = 1'b0;
        ia.div_sel = '0;  ib.div_sel = '0;
        ia.end_uut = 1'b0; ib.end_uut = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst = 1'b1;
            checks++;
            if ({ia.clk_en_uut, ia.rst_uut, ia.busy, ia.done, ia.timeout, ia.cycles} !== {5'b01000, 32'd0}) begin
                errors++;
                $display("FAIL reset_a k=%0d got %b/%0d exp 01000/0", k,
                         {ia.clk_en_uut, ia.rst_uut, ia.busy, ia.done, ia.timeout}, ia.cycles);
            end
            checks++;
            if ({ib.clk_en_uut, ib.rst_uut, ib.busy, ib.done, ib.timeout, ib.cycles} !== {5'b01000, 4'd0}) begin
                errors++;
                $display("FAIL reset_b k=%0d got %b/%0d exp 01000/0", k,
                         {ib.clk_en_uut, ib.rst_uut, ib.busy, ib.done, ib.timeout}, ib.cycles);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        run_case("basic", 0, 5, 1'b0, 3, -1);
    endtask

    task automatic test_divided();
        run_case("div8", 3, 1, 1'b0, 3, -1);
    endtask

    task automatic test_timeout();
        run_case("timeout", 0, 30, 1'b0, 0, -1);
        run_case("after_timeout", 0, 2, 1'b0, 2, -1);
        run_case("end_at_limit", 1, 10, 1'b0, 2, -1);
    endtask

    task automatic test_saturate();
        run_case("saturate", 0, 20, 1'b0, 2, -1);
    endtask

    task automatic test_start_noise();
        run_case("noise", 0, 12, 1'b1, 2, -1);
        run_case("noise_div", 2, 6, 1'b1, 2, -1);
    endtask

    task automatic test_clamp();
        run_case("clamp5", 5, 3, 1'b0, 2, -1);
        run_case("clamp7", 7, 2, 1'b0, 1, -1);
    endtask

    task automatic test_reset_mid_run();
        run_case("rst_mid", 1, 40, 1'b0, 0, (A_RST + 3) * 2 + 1);
        checks++;
        if (ia.cycles !== 32'd3) begin
            errors++;
            $display("FAIL rst_mid_pre cycles got %0d exp 3", ia.cycles);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) rst = 1'b1;
            checks++;
            if ({ia.clk_en_uut, ia.rst_uut, ia.busy, ia.done, ia.timeout, ia.cycles} !== {5'b01000, 32'd0}) begin
                errors++;
                $display("FAIL rst_mid_a k=%0d got %b/%0d exp 01000/0", k,
                         {ia.clk_en_uut, ia.rst_uut, ia.busy, ia.done, ia.timeout}, ia.cycles);
            end
            checks++;
            if ({ib.clk_en_uut, ib.rst_uut, ib.busy, ib.done, ib.timeout, ib.cycles} !== {5'b01000, 4'd0}) begin
                errors++;
                $display("FAIL rst_mid_b k=%0d got %b/%0d exp 01000/0", k,
                         {ib.clk_en_uut, ib.rst_uut, ib.busy, ib.done, ib.timeout}, ib.cycles);
            end
            @(negedge clk);
        end
        run_case("after_rst", 2, 4, 1'b0, 2, -1);
    endtask

    task automatic test_back_to_back();
        run_case("b2b_1", 1, 3, 1'b0, 0, -1);
        run_case("b2b_2", 0, 7, 1'b0, 0, -1);
        run_case("b2b_3", 2, 2, 1'b0, 2, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_case("random", int'($urandom_range(0, 4)), int'($urandom_range(1, 24)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divided();
        test_timeout();
        test_saturate();
        test_start_noise();
        test_clamp();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
